// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin write-back arbiter for the register bank's
// single write port. Two requesters (A: ALU, B: load/multi-cycle unit) are
// granted at most one per cycle, and the winning write is registered into a
// one-stage output that drives RegWrite/WriteRegister/WriteData.
//
// Optional feature macro: WB_ARB_BYPASS_EN
//   defined   -> the in-flight write is forwarded onto ReadData1/ReadData2
//   undefined -> ReadDataK is a plain passthrough of RfReadDataK
module regfile_wb_arbiter #(
  parameter int N  = 32,
  parameter int BR = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          AValid,
  input  logic [BR-1:0] AReg,
  input  logic [N-1:0]  AData,
  output logic          AReady,
  input  logic          BValid,
  input  logic [BR-1:0] BReg,
  input  logic [N-1:0]  BData,
  output logic          BReady,
  output logic          RegWrite,
  output logic [BR-1:0] WriteRegister,
  output logic [N-1:0]  WriteData,
  input  logic [BR-1:0] ReadRegister1,
  input  logic [BR-1:0] ReadRegister2,
  input  logic [N-1:0]  RfReadData1,
  input  logic [N-1:0]  RfReadData2,
  output logic [N-1:0]  ReadData1,
  output logic [N-1:0]  ReadData2
);

  // Round-robin preference: which requester wins when both are valid.
  typedef enum logic {
    PREF_A = 1'b0,
    PREF_B = 1'b1
  } pref_t;

  pref_t pref;
  pref_t pref_next;

  // Grant decode and next preference; nothing is granted while in reset.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/else chain leaves a signal unassigned (no latch).
    AReady    = 1'b0;
    BReady    = 1'b0;
    pref_next = pref;
    if (!rst) begin
      if (AValid && (!BValid || pref == PREF_A)) begin
        AReady    = 1'b1;
        pref_next = PREF_B;
      end else if (BValid) begin
        BReady    = 1'b1;
        pref_next = PREF_A;
      end
    end
  end

  // Preference register and registered write-port stage.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      pref          <= PREF_A;
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else begin
      pref <= pref_next;
      if (AReady) begin
        RegWrite      <= (AReg != '0);
        WriteRegister <= AReg;
        WriteData     <= AData;
      end else if (BReady) begin
        RegWrite      <= (BReg != '0);
        WriteRegister <= BReg;
        WriteData     <= BData;
      end else begin
        // Idle cycle: no write; address/data hold their last values.
        RegWrite <= 1'b0;
      end
    end
  end

`ifdef WB_ARB_BYPASS_EN
  // Forward the write being committed this cycle to a matching read port.
  // Register 0 is never forwarded since it never holds a written value.
  assign ReadData1 = (RegWrite && WriteRegister == ReadRegister1 && ReadRegister1 != '0)
                     ? WriteData : RfReadData1;
  assign ReadData2 = (RegWrite && WriteRegister == ReadRegister2 && ReadRegister2 != '0)
                     ? WriteData : RfReadData2;
`else
  // No forwarding: the datapath schedules around the write-to-read gap.
  logic unused_read_regs;
  assign unused_read_regs = ^{ReadRegister1, ReadRegister2};
  assign ReadData1 = RfReadData1;
  assign ReadData2 = RfReadData2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter. Inputs change 1 ns after the
// rising edge; outputs are checked before the next rising edge. A small bank
// model captures committed writes so the same-destination ordering can be
// checked on the final register value.
module tb_regfile_wb_arbiter;

  localparam int N  = 32;
  localparam int BR = 5;

  logic          clk;
  logic          rst;
  logic          AValid;
  logic [BR-1:0] AReg;
  logic [N-1:0]  AData;
  logic          AReady;
  logic          BValid;
  logic [BR-1:0] BReg;
  logic [N-1:0]  BData;
  logic          BReady;
  logic          RegWrite;
  logic [BR-1:0] WriteRegister;
  logic [N-1:0]  WriteData;
  logic [BR-1:0] ReadRegister1;
  logic [BR-1:0] ReadRegister2;
  logic [N-1:0]  RfReadData1;
  logic [N-1:0]  RfReadData2;
  logic [N-1:0]  ReadData1;
  logic [N-1:0]  ReadData2;

  int total = 0;
  int bad   = 0;

  logic [N-1:0] bank [32];
  logic [N-1:0] exp_fwd;

  regfile_wb_arbiter #(.N(N), .BR(BR)) dut (
    .clk           (clk),
    .rst           (rst),
    .AValid        (AValid),
    .AReg          (AReg),
    .AData         (AData),
    .AReady        (AReady),
    .BValid        (BValid),
    .BReg          (BReg),
    .BData         (BData),
    .BReady        (BReady),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .RfReadData1   (RfReadData1),
    .RfReadData2   (RfReadData2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank model: captures the registered write on each rising edge.
  always @(posedge clk) begin
    if (RegWrite) bank[WriteRegister] <= WriteData;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    AValid        = 1'b1;
    AReg          = 5'd3;
    AData         = 32'h33;
    BValid        = 1'b1;
    BReg          = 5'd4;
    BData         = 32'h44;
    ReadRegister1 = '0;
    ReadRegister2 = '0;
    RfReadData1   = '0;
    RfReadData2   = '0;

    // Reset held 3 cycles with both requesters valid.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_aready", {31'b0, AReady}, 32'd0);
      check("rst_bready", {31'b0, BReady}, 32'd0);
      check("rst_regwrite", {31'b0, RegWrite}, 32'd0);
      check("rst_wreg", {27'b0, WriteRegister}, 32'd0);
      check("rst_wdata", WriteData, 32'd0);
    end

    // Contention: A first, then alternating.
    rst = 1'b0;
    #1;
    check("cont_first_a", {31'b0, AReady}, 32'd1);
    check("cont_first_b", {31'b0, BReady}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("cont_regwrite", {31'b0, RegWrite}, 32'd1);
      check("cont_wreg", {27'b0, WriteRegister}, (i % 2 == 0) ? 32'd3 : 32'd4);
      check("cont_wdata", WriteData, (i % 2 == 0) ? 32'h33 : 32'h44);
      if (i < 3) begin
        check("cont_aready", {31'b0, AReady}, (i % 2 == 1) ? 32'd1 : 32'd0);
        check("cont_bready", {31'b0, BReady}, (i % 2 == 0) ? 32'd1 : 32'd0);
      end else begin
        AValid = 1'b0;
        BValid = 1'b0;
      end
    end
    tick();
    check("idle_regwrite", {31'b0, RegWrite}, 32'd0);
    check("idle_wreg_hold", {27'b0, WriteRegister}, 32'd4);
    check("idle_wdata_hold", WriteData, 32'h44);

    // Lone requester A, one accepted cycle.
    AValid = 1'b1;
    AReg   = 5'd5;
    AData  = 32'hDEADBEEF;
    #1;
    check("lone_aready", {31'b0, AReady}, 32'd1);
    tick();
    AValid = 1'b0;
    check("lone_regwrite", {31'b0, RegWrite}, 32'd1);
    check("lone_wreg", {27'b0, WriteRegister}, 32'd5);
    check("lone_wdata", WriteData, 32'hDEADBEEF);
    tick();
    check("lone_after", {31'b0, RegWrite}, 32'd0);

    // Write to register 0: handshake completes, no bank write.
    BValid = 1'b1;
    BReg   = 5'd0;
    BData  = 32'h1234;
    #1;
    check("zero_bready", {31'b0, BReady}, 32'd1);
    check("zero_aready", {31'b0, AReady}, 32'd0);
    tick();
    BValid = 1'b0;
    check("zero_regwrite", {31'b0, RegWrite}, 32'd0);
    check("zero_wdata", WriteData, 32'h1234);

    // Same destination, Pref=A: 0x11 then 0x22.
    AValid = 1'b1;
    AReg   = 5'd7;
    AData  = 32'h11;
    BValid = 1'b1;
    BReg   = 5'd7;
    BData  = 32'h22;
    #1;
    check("same_aready", {31'b0, AReady}, 32'd1);
    tick();
    AValid = 1'b0;
    #1;
    check("same_bready", {31'b0, BReady}, 32'd1);
    check("same_first_we", {31'b0, RegWrite}, 32'd1);
    check("same_first_data", WriteData, 32'h11);
    tick();
    BValid = 1'b0;
    check("same_second_we", {31'b0, RegWrite}, 32'd1);
    check("same_second_reg", {27'b0, WriteRegister}, 32'd7);
    check("same_second_data", WriteData, 32'h22);
    tick();
    check("same_bank_r7", bank[7], 32'h22);

    // Forwarding of an in-flight write to reg 9.
    AValid = 1'b1;
    AReg   = 5'd9;
    AData  = 32'hCAFE;
    tick();
    AValid        = 1'b0;
    ReadRegister1 = 5'd9;
    RfReadData1   = 32'h0;
    ReadRegister2 = 5'd0;
    RfReadData2   = 32'h5555;
`ifdef WB_ARB_BYPASS_EN
    exp_fwd = 32'hCAFE;
`else
    exp_fwd = 32'h0;
`endif
    #1;
    check("fwd_rd1", ReadData1, exp_fwd);
    check("fwd_rd2_zero", ReadData2, 32'h5555);
    ReadRegister2 = 5'd3;
    RfReadData2   = 32'h7777;
    #1;
    check("fwd_rd2_miss", ReadData2, 32'h7777);
    tick();
    RfReadData1 = 32'hAAAA;
    #1;
    check("fwd_rd1_idle", ReadData1, 32'hAAAA);

    // Lone A held valid: accepted every cycle.
    for (int i = 0; i < 3; i++) begin
      AValid = 1'b1;
      AReg   = 5'd12;
      AData  = 32'h100 + i;
      #1;
      check("held_aready", {31'b0, AReady}, 32'd1);
      tick();
      check("held_wdata", WriteData, 32'h100 + i);
    end

    // Reset mid-operation: pending write dropped, Pref back to A.
    rst    = 1'b1;
    BValid = 1'b1;
    BReg   = 5'd4;
    #1;
    check("midrst_aready", {31'b0, AReady}, 32'd0);
    check("midrst_bready", {31'b0, BReady}, 32'd0);
    tick();
    check("midrst_regwrite", {31'b0, RegWrite}, 32'd0);
    check("midrst_wreg", {27'b0, WriteRegister}, 32'd0);
    rst = 1'b0;
    #1;
    check("midrst_pref_a", {31'b0, AReady}, 32'd1);
    AValid = 1'b0;
    BValid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
